up_counter_ctrl: RTL and testbench
==================================

# up_counter_ctrl

Controller that sequences the team's WIDTH-bit up counter into a programmable interval timer. Software-side logic loads a terminal value and mode through a valid/ready handshake, then starts and stops counting. The block produces the count, a busy flag and a one-cycle `done` pulse at each terminal count. It sits between the configuration interface and any logic that needs periodic or one-shot timing events.

## Interface
- `WIDTH`, 32, width of the count and the terminal value.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cfg_valid` input 1: configuration offer.
- `cfg_ready` output 1: block accepts configuration this cycle.
- `cfg_limit` input WIDTH: terminal count, captured when `cfg_valid && cfg_ready`.
- `cfg_reload` input 1: 1 = auto-reload, 0 = one-shot; captured with `cfg_limit`.
- `start` input 1: level-sampled start request.
- `stop` input 1: level-sampled stop request.
- `cnt` output WIDTH: current count.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse per terminal count.

## Operation
- States: IDLE, ARMED, RUN, DONE. Registers: `limit_q`, `reload_q`, `cnt`.
- Reset values: IDLE, `cnt`=0, `limit_q`=0, `reload_q`=0, `done`=0, `busy`=0, `cfg_ready`=1.
- `cfg_ready` = 1 in IDLE, ARMED and DONE; 0 in RUN. A handshake in any of these states captures config and moves to ARMED. `cnt` is unchanged.
- ARMED: `start`=1 and `stop`=0 moves to RUN, with `cnt` <- 0 on the same edge. If `start` and `stop` are both high, `stop` wins and the state stays ARMED.
- RUN: on each tick, if `cnt` != `limit_q`, then `cnt` <- `cnt`+1. If `cnt` == `limit_q`, then:
  - `done` is set for the next cycle;
  - in reload mode, `cnt` <- 0 and the state stays RUN;
  - in one-shot mode, the state moves to DONE and `cnt` holds `limit_q`.
- RUN with `stop`=1: moves to ARMED and `cnt` holds its value. `start` is ignored in RUN.
- Stop and terminal count on the same edge: `done` still pulses, `cnt` still updates per mode, and the next state is ARMED.
- DONE: `start` moves to RUN with `cnt` <- 0. A config handshake moves to ARMED.
- Counting arithmetic:
  - `cnt` never exceeds `limit_q`, so no wrap-around occurs.
  - `limit_q` = 2^WIDTH-1 is legal.
  - `limit_q` = 0 gives `done` on every tick in reload mode.
- `rst` mid-operation immediately forces all reset values, regardless of state or handshake in progress.

## Timing
- Start accepted at edge k: `cnt`=0 after k and `cnt`=n after edge k+n.
- `cnt` reaches `limit_q` after edge k+L, where L = `limit_q`.
- `done` is high for exactly the cycle after edge k+L+1.
- Reload period = L+1 ticks. Consecutive `done` pulses are L+1 cycles apart (no prescale).
- `busy` is registered: it goes high the cycle after the start edge and low the cycle after the stop or one-shot-terminal edge.
- The config capture appears in `limit_q` one edge after the handshake. A start on the same edge as a handshake from IDLE is ignored.

## Configuration
- Macro `UP_CNT_CTRL_PRESCALE_EN`.
- Defined:
  - Adds input `cfg_div` [7:0], captured with the config.
  - An internal 8-bit prescaler produces one tick every `cfg_div`+1 clocks while in RUN.
  - The prescaler clears on start, on stop and on reset.
  - `done` remains a single-clock pulse.
- Undefined: no `cfg_div` port, and a tick occurs on every clock in RUN.

## Test plan
- Reset check: assert `rst` asynchronously mid-RUN with `cnt`=5. Expect `cnt`=0, `busy`=0, `done`=0 and `cfg_ready`=1 immediately; after release the state is IDLE.
- One-shot: `cfg_limit`=3, reload=0, then start. Expect `cnt` 0,1,2,3; `done` high one cycle, 4 cycles after the start edge; `cnt` holds 3 and `busy`=0.
- Auto-reload: `cfg_limit`=2, reload=1. Expect `cnt` 0,1,2,0,1,2 and `done` every 3 cycles, across 100 periods.
- Stop/terminal collision: limit=4, reload=1, `stop` asserted on the edge where `cnt`=4. Expect one `done` pulse, `cnt`=0 and the state ARMED. A later start restarts from 0.
- Handshake blocking: `cfg_valid` held high during RUN. Expect `cfg_ready`=0 and `limit_q` unchanged. After stop, the handshake completes in ARMED.
- With `UP_CNT_CTRL_PRESCALE_EN` defined: `cfg_div`=3, limit=1, reload=1. Expect `cnt` to advance every 4 clocks and `done` to pulse every 8 clocks.

Source files
------------

// File: rtl/up_counter_ctrl_if.sv
// up_counter_ctrl_if: configuration, control and status bundle for up_counter_ctrl.
//
// Signals:
//   cfg_valid  - configuration offer (master -> slave)
//   cfg_ready  - slave accepts configuration this cycle (slave -> master)
//   cfg_limit  - terminal count, captured on cfg_valid && cfg_ready
//   cfg_reload - 1 = auto-reload, 0 = one-shot, captured with cfg_limit
//   cfg_div    - prescale divider, present only with UP_CNT_CTRL_PRESCALE_EN
//   start      - level-sampled start request
//   stop       - level-sampled stop request
//   cnt        - current count
//   busy       - high while counting
//   done       - one-cycle pulse per terminal count
//
// Modports: master drives configuration/control, slave is the controller.
interface up_counter_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_reload;
`ifdef UP_CNT_CTRL_PRESCALE_EN
  logic [7:0]       cfg_div;
`endif
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;

`ifdef UP_CNT_CTRL_PRESCALE_EN
  modport master (
    output cfg_valid, cfg_limit, cfg_reload, cfg_div, start, stop,
    input  cfg_ready, cnt, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_reload, cfg_div, start, stop,
    output cfg_ready, cnt, busy, done
  );
`else
  modport master (
    output cfg_valid, cfg_limit, cfg_reload, start, stop,
    input  cfg_ready, cnt, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_limit, cfg_reload, start, stop,
    output cfg_ready, cnt, busy, done
  );
`endif

endinterface

// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl: sequences a WIDTH-bit up counter into a programmable interval timer.
//
// A terminal value and mode (one-shot / auto-reload) are loaded through a valid/ready
// handshake, after which start/stop control counting. Each terminal count produces a
// one-cycle done pulse; one-shot mode then parks in DONE holding the terminal value.
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - up_counter_ctrl_if.slave (cfg_valid/ready/limit/reload[/div], start, stop,
//         cnt, busy, done)
//
// Optional feature (define UP_CNT_CTRL_PRESCALE_EN): adds cfg_div and an 8-bit prescaler
// so the counter advances once every cfg_div+1 clocks while running. Without the macro
// the counter advances on every clock in RUN.
module up_counter_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  up_counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;

  logic             cfg_hs;
  logic             tick;
  logic             at_limit;

`ifdef UP_CNT_CTRL_PRESCALE_EN
  logic [7:0]       div_q, div_d;
  logic [7:0]       presc_q, presc_d;

  assign tick = (presc_q == div_q);
`else
  assign tick = 1'b1;
`endif

  // Configuration is accepted in every state except RUN.
  assign cfg_hs   = bus.cfg_valid && (state_q != StRun);
  assign at_limit = (cnt_q == limit_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    reload_d = reload_q;
    done_d   = 1'b0;
`ifdef UP_CNT_CTRL_PRESCALE_EN
    div_d    = div_q;
    presc_d  = presc_q;
`endif

    unique case (state_q)
      StIdle, StArmed, StDone: begin
        if (cfg_hs) begin
          // Handshake wins over a simultaneous start.
          limit_d  = bus.cfg_limit;
          reload_d = bus.cfg_reload;
`ifdef UP_CNT_CTRL_PRESCALE_EN
          div_d    = bus.cfg_div;
`endif
          state_d  = StArmed;
        end else if (bus.start &&
                     (((state_q == StArmed) && !bus.stop) || (state_q == StDone))) begin
          state_d = StRun;
          cnt_d   = '0;
`ifdef UP_CNT_CTRL_PRESCALE_EN
          presc_d = 8'd0;
`endif
        end
      end

      StRun: begin
`ifdef UP_CNT_CTRL_PRESCALE_EN
        presc_d = tick ? 8'd0 : presc_q + 8'd1;
`endif
        if (tick) begin
          if (at_limit) begin
            done_d = 1'b1;
            if (reload_q) begin
              cnt_d = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            // cnt_q < limit_q here, so the increment cannot wrap.
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        // Stop overrides both RUN and the one-shot move to DONE; the tick still applies.
        if (bus.stop) begin
          state_d = StArmed;
`ifdef UP_CNT_CTRL_PRESCALE_EN
          presc_d = 8'd0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UP_CNT_CTRL_PRESCALE_EN
      div_q    <= 8'd0;
      presc_q  <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      done_q   <= done_d;
`ifdef UP_CNT_CTRL_PRESCALE_EN
      div_q    <= div_d;
      presc_q  <= presc_d;
`endif
    end
  end

  assign bus.cfg_ready = (state_q != StRun);
  assign bus.busy      = (state_q == StRun);
  assign bus.cnt       = cnt_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb_up_counter_ctrl: directed and randomized bench for up_counter_ctrl.
//
// The reference model tracks the timer by elapsed clocks/ticks since start and derives
// the count arithmetically (modulo period in reload mode, saturating in one-shot mode).
// A negedge process compares every output against the model each cycle; directed
// sequences add literal expectations for the key timing points.
module tb_up_counter_ctrl;

  localparam int unsigned W = 32;

  localparam int PhIdle  = 0;
  localparam int PhArmed = 1;
  localparam int PhRun   = 2;
  localparam int PhDone  = 3;

  logic clk;
  logic rst;

  up_counter_ctrl_if #(.WIDTH(W)) bus_if ();

  up_counter_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model state.
  int              m_phase;
  longint unsigned m_lim;
  bit              m_reload;
  int              m_div;
  longint unsigned m_ticks;
  longint unsigned m_clks;
  longint unsigned m_cnt;
  bit              m_done;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = PhIdle;
    m_lim    = 0;
    m_reload = 1'b0;
    m_div    = 0;
    m_ticks  = 0;
    m_clks   = 0;
    m_cnt    = 0;
    m_done   = 1'b0;
  endtask

  // One rising edge of the specification's behaviour, using the inputs as sampled.
  task automatic model_step();
    bit tick;
    bit done_n;
    if (rst) begin
      model_reset();
      return;
    end
    done_n = 1'b0;
    if (m_phase != PhRun) begin
      if (bus_if.cfg_valid) begin
        m_lim    = longint'(bus_if.cfg_limit);
        m_reload = bus_if.cfg_reload;
`ifdef UP_CNT_CTRL_PRESCALE_EN
        m_div    = int'(bus_if.cfg_div);
`else
        m_div    = 0;
`endif
        m_phase  = PhArmed;
      end else if (bus_if.start &&
                   ((m_phase == PhDone) || (m_phase == PhArmed && !bus_if.stop))) begin
        m_phase = PhRun;
        m_ticks = 0;
        m_clks  = 0;
        m_cnt   = 0;
      end
    end else begin
      tick   = ((m_clks % longint'(m_div + 1)) == longint'(m_div));
      m_clks = m_clks + 1;
      if (tick) begin
        m_ticks = m_ticks + 1;
        if ((m_ticks % (m_lim + 1)) == 0) begin
          done_n = 1'b1;
          if (!m_reload) m_phase = PhDone;
        end
        m_cnt = m_reload ? (m_ticks % (m_lim + 1)) : ((m_ticks > m_lim) ? m_lim : m_ticks);
      end
      if (bus_if.stop) m_phase = PhArmed;
    end
    m_done = done_n;
  endtask

  // Single compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cnt",       {32'd0, bus_if.cnt},  m_cnt);
      chk("busy",      {63'd0, bus_if.busy}, {63'd0, (m_phase == PhRun)});
      chk("done",      {63'd0, bus_if.done}, {63'd0, m_done});
      chk("cfg_ready", {63'd0, bus_if.cfg_ready}, {63'd0, (m_phase != PhRun)});
    end
  end

  // Advance one clock: model follows the edge, returns just after the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic configure(input logic [W-1:0] lim, input bit rl, input int div);
    bus_if.cfg_valid  = 1'b1;
    bus_if.cfg_limit  = lim;
    bus_if.cfg_reload = rl;
`ifdef UP_CNT_CTRL_PRESCALE_EN
    bus_if.cfg_div    = 8'(div);
`else
    if (div != 0) $display("note: cfg_div ignored without prescaler");
`endif
    cyc();
    bus_if.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
  endtask

  task automatic do_stop();
    bus_if.stop = 1'b1;
    cyc();
    bus_if.stop = 1'b0;
  endtask

  initial begin
    int nd;
    rst               = 1'b1;
    bus_if.cfg_valid  = 1'b0;
    bus_if.cfg_limit  = '0;
    bus_if.cfg_reload = 1'b0;
`ifdef UP_CNT_CTRL_PRESCALE_EN
    bus_if.cfg_div    = 8'd0;
`endif
    bus_if.start      = 1'b0;
    bus_if.stop       = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst    = 1'b0;
    chk_en = 1'b1;
    cyc();

    // Reset state.
    chk("rst_cnt",   {32'd0, bus_if.cnt},       64'd0);
    chk("rst_busy",  {63'd0, bus_if.busy},      64'd0);
    chk("rst_done",  {63'd0, bus_if.done},      64'd0);
    chk("rst_ready", {63'd0, bus_if.cfg_ready}, 64'd1);

    // One-shot, limit 3.
    configure(32'd3, 1'b0, 0);
    do_start();
    chk("os_cnt0", {32'd0, bus_if.cnt},  64'd0);
    chk("os_busy", {63'd0, bus_if.busy}, 64'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("os_cnt", {32'd0, bus_if.cnt},  64'(i));
      chk("os_nodone", {63'd0, bus_if.done}, 64'd0);
    end
    cyc();
    chk("os_done",     {63'd0, bus_if.done}, 64'd1);
    chk("os_hold",     {32'd0, bus_if.cnt},  64'd3);
    chk("os_busy_low", {63'd0, bus_if.busy}, 64'd0);
    cyc();
    chk("os_done_pulse", {63'd0, bus_if.done}, 64'd0);
    chk("os_hold2",      {32'd0, bus_if.cnt},  64'd3);

    // Asynchronous reset mid-RUN at cnt = 5.
    configure(32'd10, 1'b0, 0);
    do_start();
    repeat (5) cyc();
    chk("mid_cnt5", {32'd0, bus_if.cnt}, 64'd5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_cnt",   {32'd0, bus_if.cnt},       64'd0);
    chk("arst_busy",  {63'd0, bus_if.busy},      64'd0);
    chk("arst_done",  {63'd0, bus_if.done},      64'd0);
    chk("arst_ready", {63'd0, bus_if.cfg_ready}, 64'd1);
    cyc();
    rst = 1'b0;
    cyc();
    do_start();
    chk("idle_ignores_start", {63'd0, bus_if.busy}, 64'd0);

    // Auto-reload, limit 2, 100 periods.
    configure(32'd2, 1'b1, 0);
    do_start();
    nd = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc();
      if (bus_if.done) nd++;
      chk("ar_cnt", {32'd0, bus_if.cnt}, 64'(n % 3));
      chk("ar_done", {63'd0, bus_if.done}, 64'((n % 3) == 0));
    end
    chk("ar_done_count", 64'(nd), 64'd100);
    do_stop();

    // Stop on the terminal edge in reload mode.
    configure(32'd4, 1'b1, 0);
    do_start();
    repeat (4) cyc();
    chk("col_cnt4", {32'd0, bus_if.cnt}, 64'd4);
    do_stop();
    chk("col_done",  {63'd0, bus_if.done},      64'd1);
    chk("col_cnt",   {32'd0, bus_if.cnt},       64'd0);
    chk("col_armed", {63'd0, bus_if.busy},      64'd0);
    chk("col_ready", {63'd0, bus_if.cfg_ready}, 64'd1);
    cyc();
    chk("col_single", {63'd0, bus_if.done}, 64'd0);
    do_start();
    chk("col_restart0", {32'd0, bus_if.cnt}, 64'd0);
    cyc();
    chk("col_restart1", {32'd0, bus_if.cnt}, 64'd1);

    // Handshake blocked in RUN, completes in ARMED after stop.
    bus_if.cfg_valid  = 1'b1;
    bus_if.cfg_limit  = 32'd7;
    bus_if.cfg_reload = 1'b0;
    repeat (3) begin
      cyc();
      chk("blk_ready", {63'd0, bus_if.cfg_ready}, 64'd0);
    end
    do_stop();
    chk("blk_ready_armed", {63'd0, bus_if.cfg_ready}, 64'd1);
    cyc();
    bus_if.cfg_valid = 1'b0;
    do_start();
    repeat (7) cyc();
    chk("blk_newlim", {32'd0, bus_if.cnt}, 64'd7);
    cyc();
    chk("blk_done", {63'd0, bus_if.done}, 64'd1);

    // Boundary limits: all-ones and zero.
    configure(32'hFFFF_FFFF, 1'b1, 0);
    do_start();
    repeat (5) cyc();
    chk("max_cnt", {32'd0, bus_if.cnt}, 64'd5);
    do_stop();
    configure(32'd0, 1'b1, 0);
    do_start();
    repeat (5) begin
      cyc();
      chk("zero_done", {63'd0, bus_if.done}, 64'd1);
      chk("zero_cnt",  {32'd0, bus_if.cnt},  64'd0);
    end
    do_stop();

`ifdef UP_CNT_CTRL_PRESCALE_EN
    // Prescaler: div 3, limit 1, reload.
    configure(32'd1, 1'b1, 3);
    do_start();
    nd = 0;
    for (int n = 1; n <= 32; n++) begin
      cyc();
      if (bus_if.done) nd++;
      chk("ps_cnt",  {32'd0, bus_if.cnt},  64'((n / 4) % 2));
      chk("ps_done", {63'd0, bus_if.done}, 64'((n % 8) == 0));
    end
    chk("ps_done_count", 64'(nd), 64'd4);
    do_stop();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst               = ($urandom_range(0, 299) == 0);
      bus_if.cfg_valid  = ($urandom_range(0, 7) == 0);
      bus_if.cfg_limit  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF :
                          32'($urandom_range(0, 6));
      bus_if.cfg_reload = $urandom_range(0, 1) == 1;
`ifdef UP_CNT_CTRL_PRESCALE_EN
      bus_if.cfg_div    = 8'($urandom_range(0, 3));
`endif
      bus_if.start      = ($urandom_range(0, 3) == 0);
      bus_if.stop       = ($urandom_range(0, 15) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
